// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline constants and types used by the write-back stage,
// the register file and the forwarding unit.
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/wb_regfile_if.sv
// MEM/WB -> write-back bundle plus the ID-stage read ports and debug port.
// master drives the pipeline side, slave is the register file.
interface wb_regfile_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    import riscv_pkg::*;

    // MEM/WB pipeline register outputs
    logic            RegWrite_WB;
    logic            MemtoReg_WB;
    logic [XLEN-1:0] DataOut_WB;
    logic [XLEN-1:0] AluOut_WB;
    reg_addr_t       Rd_WB;

    // ID-stage operand reads
    reg_addr_t       Rs1;
    reg_addr_t       Rs2;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;

    // Write-back result exported to forwarding
    logic [XLEN-1:0] WriteData;
    logic            WriteValid;

    // Debug peek, never bypassed
    reg_addr_t       dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output RegWrite_WB, MemtoReg_WB, DataOut_WB, AluOut_WB, Rd_WB,
        output Rs1, Rs2, dbg_addr,
        input  ReadData1, ReadData2, WriteData, WriteValid, dbg_data
    );

    modport slave (
        input  RegWrite_WB, MemtoReg_WB, DataOut_WB, AluOut_WB, Rd_WB,
        input  Rs1, Rs2, dbg_addr,
        output ReadData1, ReadData2, WriteData, WriteValid, dbg_data
    );

endinterface : wb_regfile_if

// File: rtl/wb_mux.sv
// MemtoReg write-back selector; kept standalone so the forwarding unit can
// reuse the exact same selection.
module wb_mux #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            sel_mem,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] alu_data,
    output logic [XLEN-1:0] wb_data
);

    assign wb_data = sel_mem ? mem_data : alu_data;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Write-back stage and 32 x XLEN integer register file with two combinational
// read ports, optional same-cycle write bypass and an unbypassed debug port.
module wb_regfile #(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int NREG      = riscv_pkg::NREG,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    import riscv_pkg::*;

    logic [XLEN-1:0] wdata;
    logic            wvalid;
    logic [NREG-1:1] wr_en;
    logic [XLEN-1:0] regs [1:NREG-1];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] dbg;

    // x0 has no storage; unimplemented addresses also read as zero.
    function automatic logic [XLEN-1:0] stored(input reg_addr_t addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr != REG_ZERO && int'(addr) < NREG)
            val = regs[addr];
        return val;
    endfunction

    function automatic logic [XLEN-1:0] read_port(
        input reg_addr_t       rs,
        input reg_addr_t       rd,
        input logic            valid,
        input logic [XLEN-1:0] fwd
    );
        logic [XLEN-1:0] val;
        if (rs == REG_ZERO)
            val = '0;
        else if (BYPASS_EN && valid && rd == rs)
            val = fwd;
        else
            val = stored(rs);
        return val;
    endfunction

    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .sel_mem  (bus.MemtoReg_WB),
        .mem_data (bus.DataOut_WB),
        .alu_data (bus.AluOut_WB),
        .wb_data  (wdata)
    );

    assign wvalid = bus.RegWrite_WB && (bus.Rd_WB != REG_ZERO);

    // Per-register one-hot enable: an unknown enable or address can only
    // disturb the register it actually decodes to.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NREG; i++)
            wr_en[i] = wvalid && (bus.Rd_WB == reg_addr_t'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                if (wr_en[i])
                    regs[i] <= wdata;
        end
    end

    // While reset is held every register reads zero, bypass included.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        dbg = '0;
        if (!reset) begin
            rd1 = read_port(bus.Rs1, bus.Rd_WB, wvalid, wdata);
            rd2 = read_port(bus.Rs2, bus.Rd_WB, wvalid, wdata);
            dbg = stored(bus.dbg_addr);
        end
    end

    assign bus.ReadData1  = rd1;
    assign bus.ReadData2  = rd2;
    assign bus.dbg_data   = dbg;
    assign bus.WriteData  = wdata;
    assign bus.WriteValid = wvalid;

endmodule : wb_regfile
